// File: rtl/prbs_burst_ctrl.sv
// prbs_burst_ctrl: burst sequencer around an 8-bit PRBS LFSR (x^8+x^4+x^3+x^2+1).
// A host loads a seed and a bit count with start. The block then emits exactly
// that many PRBS bits, one every DIV_MAX+1 clk cycles, each qualified by prbs_valid.
// Optional build macro PRBS_ERR_INJECT_EN adds an err_inj input. While err_inj is
// high on a tick, the emitted bit is inverted but the LFSR sequence is not affected.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start; a zero-length request only pulses done
// S_LOAD | one cycle: seed (0 replaced by 8'hFF) into LFSR, divider cleared
// S_RUN  | divider running; each tick emits one bit and shifts the LFSR
// S_DONE | one cycle after the final bit; done rises as busy falls
module prbs_burst_ctrl #(
    parameter int unsigned DIV_MAX = 3,
    parameter int unsigned LEN_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       seed,
    input  logic [LEN_W-1:0] burst_len,
    input  logic             abort,
`ifdef PRBS_ERR_INJECT_EN
    input  logic             err_inj,
`endif
    output logic             prbs_out,
    output logic             prbs_valid,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] bit_count,
    output logic [7:0]       lfsr_q
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [3:0] DIV_TC = 4'(DIV_MAX);

    state_t           state;
    logic [3:0]       div_cnt;
    logic [LEN_W-1:0] len_q;
    logic [7:0]       seed_q;
    logic             tick;
    logic             flip;
    logic [7:0]       lfsr_next;
    logic [LEN_W-1:0] count_inc;

    assign tick      = (state == S_RUN) && (div_cnt == DIV_TC);
    assign count_inc = bit_count + LEN_W'(1);

    // Polynomial feedback: MSB wraps to bit 0 and is folded into taps 2, 3 and 4.
    assign lfsr_next = {lfsr_q[6], lfsr_q[5], lfsr_q[4],
                        lfsr_q[3] ^ lfsr_q[7], lfsr_q[2] ^ lfsr_q[7],
                        lfsr_q[1] ^ lfsr_q[7], lfsr_q[0], lfsr_q[7]};

`ifdef PRBS_ERR_INJECT_EN
    assign flip = err_inj;
`else
    assign flip = 1'b0;
`endif

    // Sequencer FSM with the LFSR, divider, bit counter and all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            div_cnt    <= '0;
            len_q      <= '0;
            seed_q     <= '0;
            lfsr_q     <= 8'hFF;
            bit_count  <= '0;
            prbs_out   <= 1'b0;
            prbs_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            prbs_valid <= 1'b0;
            done       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (burst_len != '0) begin
                            len_q     <= burst_len;
                            seed_q    <= seed;
                            bit_count <= '0;
                            busy      <= 1'b1;
                            state     <= S_LOAD;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        lfsr_q  <= (seed_q == 8'h00) ? 8'hFF : seed_q;
                        div_cnt <= '0;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (tick) begin
                        div_cnt    <= '0;
                        prbs_out   <= lfsr_q[7] ^ flip;
                        prbs_valid <= 1'b1;
                        lfsr_q     <= lfsr_next;
                        bit_count  <= count_inc;
                    end else begin
                        div_cnt <= div_cnt + 4'd1;
                    end
                    // A bit on the abort edge is still emitted; abort only blocks done.
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (tick && (count_inc == len_q)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prbs_burst_ctrl.sv
// tb_prbs_burst_ctrl: randomized scoreboard bench for prbs_burst_ctrl.
// The driver pushes expected bits, LFSR states, counts and arrival cycles. A
// negedge monitor pops them and compares them whenever prbs_valid or done is seen.
// Build with PRBS_ERR_INJECT_EN defined to exercise the error-injection port.
module tb_prbs_burst_ctrl;

    localparam int DIV = 3;
    localparam int LW  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    seed = 8'h00;
    logic [LW-1:0] burst_len = '0;
    logic          abort = 1'b0;
    logic          prbs_out, prbs_valid, busy, done;
    logic [LW-1:0] bit_count;
    logic [7:0]    lfsr_q;
`ifdef PRBS_ERR_INJECT_EN
    logic          err_inj = 1'b0;
`endif

    prbs_burst_ctrl #(.DIV_MAX(DIV), .LEN_W(LW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .seed       (seed),
        .burst_len  (burst_len),
        .abort      (abort),
`ifdef PRBS_ERR_INJECT_EN
        .err_inj    (err_inj),
`endif
        .prbs_out   (prbs_out),
        .prbs_valid (prbs_valid),
        .busy       (busy),
        .done       (done),
        .bit_count  (bit_count),
        .lfsr_q     (lfsr_q)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    logic       exp_bit_q[$];
    logic [7:0] exp_lfsr_q[$];
    int         exp_cyc_q[$];
    int         exp_cnt_q[$];
    logic       done_exp = 1'b0;
    logic       chk_cnt = 1'b0;
    int         done_cyc = 0;
    int         done_cnt = 0;
    logic [7:0] done_lfsr = 8'hFF;
    logic [7:0] cur_lfsr = 8'hFF;
    int         burst_strobes = 0;
    int         inj_cyc = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference step: shift left, MSB wraps round and XORs the tap mask 0x1C.
    function automatic logic [7:0] model_step(input logic [7:0] s);
        return {s[6:0], s[7]} ^ (s[7] ? 8'h1C : 8'h00);
    endfunction

`ifdef PRBS_ERR_INJECT_EN
    always @(negedge clk) err_inj = (cyc == inj_cyc);
`endif

    // Monitor: checks every strobe and done pulse against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prbs_valid) begin
                burst_strobes++;
                if (exp_bit_q.size() == 0) begin
                    chk("unexpected_valid", prbs_valid, 1'b0);
                end else begin
                    chk("prbs_bit", prbs_out, exp_bit_q.pop_front());
                    chk("lfsr_after_bit", lfsr_q, exp_lfsr_q.pop_front());
                    chk("strobe_cycle", cyc, exp_cyc_q.pop_front());
                    chk("bit_count_at_strobe", bit_count, exp_cnt_q.pop_front());
                end
            end
            if (done) begin
                if (!done_exp) begin
                    chk("unexpected_done", done, 1'b0);
                end else begin
                    chk("done_cycle", cyc, done_cyc);
                    chk("busy_at_done", busy, 1'b0);
                    chk("lfsr_at_done", lfsr_q, done_lfsr);
                    if (chk_cnt) chk("bit_count_at_done", bit_count, done_cnt);
                    done_exp = 1'b0;
                end
            end
        end
    end

    task automatic flush();
        exp_bit_q.delete();
        exp_lfsr_q.delete();
        exp_cyc_q.delete();
        exp_cnt_q.delete();
        done_exp = 1'b0;
    endtask

    // Issue one start and queue the expected response; returns at the start-edge cycle.
    task automatic launch(input logic [7:0] sd, input int len, input int inj_k);
        logic [7:0] s;
        int se;
        se = cyc + 1;
        s = (sd == 8'h00) ? 8'hFF : sd;
        burst_strobes = 0;
        for (int k = 1; k <= len; k++) begin
            exp_bit_q.push_back(s[7] ^ (k == inj_k));
            s = model_step(s);
            exp_lfsr_q.push_back(s);
            exp_cyc_q.push_back(se + 1 + k * (DIV + 1));
            exp_cnt_q.push_back(k);
        end
        if (len == 0) begin
            done_cyc = se;
            s = cur_lfsr;
            chk_cnt = 1'b0;
        end else begin
            done_cyc = se + 2 + len * (DIV + 1);
            chk_cnt = 1'b1;
        end
        done_cnt = len;
        done_lfsr = s;
        cur_lfsr = s;
        done_exp = 1'b1;
        inj_cyc = (inj_k > 0) ? se + inj_k * (DIV + 1) : -1;
        start = 1'b1;
        seed = sd;
        burst_len = LW'(len);
        @(negedge clk); #1;
        start = 1'b0;
        if (len != 0) chk("busy_in_load", busy, 1'b1);
        else chk("busy_zero_len", busy, 1'b0);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_exp && n < budget) begin
            @(negedge clk); #1;
            if (burst_len == '0 && done_exp == 1'b0) break;
            n++;
        end
        chk("done_seen", done_exp, 1'b0);
        chk("bits_left", exp_bit_q.size(), 0);
    endtask

    task automatic wait_strobes(input int want);
        int n = 0;
        while (burst_strobes < want && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        chk("strobe_wait", burst_strobes, want);
    endtask

    initial begin
        logic [7:0] s;
        int se0;
        int len;
        int n;

        #12 rst_n = 1'b0;
        chk("rst_prbs_out", prbs_out, 1'b0);
        chk("rst_valid", prbs_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_bit_count", bit_count, 0);
        chk("rst_lfsr", lfsr_q, 8'hFF);
        @(negedge clk); #1 rst_n = 1'b1;
        @(negedge clk); #1;

        // Reference burst: bits 1,1,1,1,0 and LFSR ends at 8'h96.
        launch(8'hFF, 5, 0);
        wait_done(40);
        chk("t1_final_lfsr", lfsr_q, 8'h96);
        chk("t1_bit_count", bit_count, 5);

        // Zero seed is replaced by 8'hFF.
        launch(8'h00, 3, 0);
        wait_done(30);

        // Zero-length request: done only, busy never rises.
        launch(8'h37, 0, 0);
        n = 0;
        repeat (8) begin
            @(negedge clk); #1;
            if (busy) n++;
        end
        chk("zero_len_busy_cycles", n, 0);
        chk("zero_len_done_seen", done_exp, 1'b0);

        // Abort after the third strobe.
        launch(8'hA5, 10, 0);
        wait_strobes(3);
        abort = 1'b1;
        flush();
        @(negedge clk); #1 abort = 1'b0;
        repeat (15) @(negedge clk);
        #1;
        s = 8'hA5;
        repeat (3) s = model_step(s);
        cur_lfsr = s;
        chk("abort_bit_count", bit_count, 3);
        chk("abort_busy", busy, 1'b0);
        chk("abort_lfsr_hold", lfsr_q, s);
        launch(8'h3C, 4, 0);
        wait_done(40);

        // start spammed during RUN is ignored.
        len = 6;
        launch(8'hC3, len, 0);
        se0 = cyc;
        while (cyc < se0 + len * (DIV + 1)) begin
            start = 1'b1;
            seed = 8'($urandom);
            burst_len = LW'($urandom);
            @(negedge clk); #1;
        end
        start = 1'b0;
        wait_done(40);
        chk("spam_strobes", burst_strobes, len);

        // Asynchronous reset in the middle of a burst.
        launch(8'h5A, 8, 0);
        wait_strobes(2);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_prbs_out", prbs_out, 1'b0);
        chk("midrst_valid", prbs_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_bit_count", bit_count, 0);
        chk("midrst_lfsr", lfsr_q, 8'hFF);
        flush();
        cur_lfsr = 8'hFF;
        @(negedge clk); #1 rst_n = 1'b1;
        @(negedge clk); #1;

`ifdef PRBS_ERR_INJECT_EN
        // Second bit inverted, LFSR sequence untouched: bits 1,0,1,1,0.
        launch(8'hFF, 5, 2);
        wait_done(40);
        chk("inj_final_lfsr", lfsr_q, 8'h96);
        inj_cyc = -1;
`endif

        // Randomized bursts.
        for (int i = 0; i < 10; i++) begin
            s = 8'($urandom);
            if (i % 4 == 0) s = 8'h00;
            len = $urandom_range(1, 12);
            launch(s, len, 0);
            wait_done(len * (DIV + 1) + 12);
        end

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prbs_burst_ctrl.md
Name: prbs_burst_ctrl

Overview:
Controller and sequencer for the 8-bit LFSR PRBS datapath. It holds the LFSR and a clock-enable divider, and runs the register only during a requested burst. A start/busy/done handshake lets a host load a seed and request N bits. It then emits exactly N PRBS bits, each qualified by a valid strobe. Everything runs on the single master clock; there are no derived clocks, and the rate is set by a clock-enable tick.

Parameters:
DIV_MAX, 3, divider terminal count; one PRBS bit every DIV_MAX+1 clk cycles (legal range 0..15)
LEN_W, 16, width of burst length and bit counter

Ports:
clk  input  1  100 MHz master clock
rst_n  input  1  asynchronous active-low reset
start  input  1  burst request; sampled only in IDLE
seed  input  8  LFSR seed, captured with start
burst_len  input  LEN_W  number of bits to emit, captured with start
abort  input  1  terminate running burst
prbs_out  output  1  registered PRBS bit
prbs_valid  output  1  one-cycle strobe qualifying prbs_out
busy  output  1  high in LOAD/RUN/DONE
done  output  1  one-cycle pulse at normal burst completion
bit_count  output  LEN_W  bits emitted in current/last burst
lfsr_q  output  8  current LFSR state (debug)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, lfsr_q=8'hFF, div_cnt=0, bit_count=0.
  - prbs_out=0, prbs_valid=0, busy=0, done=0.
- LFSR update (per tick), polynomial x^8+x^4+x^3+x^2+1:
  - L0<=L7, L1<=L0, L2<=L1^L7, L3<=L2^L7, L4<=L3^L7, L5<=L4, L6<=L5, L7<=L6.
- IDLE:
  - start=1 and burst_len!=0 → capture len, bit_count<=0, go LOAD.
  - start=1 and burst_len==0 → done pulses the next cycle, state stays IDLE, LFSR untouched.
- LOAD (1 cycle):
  - lfsr_q<=seed; if seed==0, lfsr_q<=8'hFF (lock-up guard).
  - div_cnt<=0, go RUN.
- RUN:
  - div_cnt counts 0..DIV_MAX and wraps; tick = (div_cnt==DIV_MAX).
  - On tick: prbs_out<=L7 (pre-shift MSB), prbs_valid<=1, LFSR shifts, bit_count<=bit_count+1.
  - If bit_count+1==len on that tick → go DONE.
  - prbs_valid is 0 on non-tick cycles; prbs_out holds its last value.
- DONE (1 cycle): done=1, go IDLE. lfsr_q and bit_count hold.
- Latency:
  - start sampled at edge 0 → LOAD at edge 1 → first prbs_valid high after edge DIV_MAX+2.
  - Later bits follow every DIV_MAX+1 cycles.
  - Burst total from start edge to done: 2+len*(DIV_MAX+1) cycles.
- Boundary conditions:
  - start while busy: ignored.
  - abort in RUN or LOAD: next state IDLE, no done, no further prbs_valid. bit_count holds its partial value.
  - abort on the same edge as the final tick: the final bit is emitted, then abort wins and the block goes IDLE without done.
  - abort in DONE or IDLE: no effect.
  - rst_n low mid-burst: immediate return to reset values.
  - bit_count never wraps; len is at most 2^LEN_W-1.

Optional Feature:
- Macro PRBS_ERR_INJECT_EN.
- Defined: adds input port err_inj (1 bit). If err_inj=1 on a tick cycle, prbs_out<=~L7 for that bit only. The LFSR sequence is unaffected, so a downstream checker must flag exactly one error.
- Undefined: the port is absent and prbs_out always equals the pre-shift L7.

Test Plan:
1. Reset, start with seed=8'hFF, burst_len=5, DIV_MAX=3 → prbs_out at the valid strobes = 1,1,1,1,0. lfsr_q sequence FF,E3,DB,AB,4B,… Strobes 4 cycles apart; first strobe DIV_MAX+2 edges after start. done is 1 cycle, bit_count=5, busy falls with done.
2. seed=8'h00, burst_len=3 → LFSR loaded 8'hFF; same first 3 bits as test 1 (1,1,1).
3. burst_len=0 with start → done pulses once, busy never rises, no prbs_valid.
4. burst_len=10, abort after the 3rd strobe → no 4th strobe, no done, bit_count=3, IDLE. A new start then succeeds.
5. Assert start repeatedly during RUN → ignored; exactly burst_len strobes are emitted. Drop rst_n mid-burst → all outputs return to reset values asynchronously.
6. With PRBS_ERR_INJECT_EN defined, seed=8'hFF, len=5, err_inj on the 2nd tick → bits 1,0,1,1,0; lfsr_q sequence unchanged from test 1.
